// File: rtl/ifetch_queue.sv
// Prefetch queue: fetches sequential words ahead of the core PC over a single-outstanding req/ack port.
// A head word written at edge N hits in cycle N+1. Requests are issued only while the queue has space.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_i,
  input  logic        fetch_en_i,
  output logic [31:0] instr_o,
  output logic        instr_valid_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  // Addresses are held word-granular; byte offsets are always zero.
  logic [29:0]   fpc_q, fpc_d;
  logic [29:0]   req_addr_q, req_addr_d;

  logic [29:0]   entry_addr_q [DEPTH];
  logic [31:0]   entry_data_q [DEPTH];

  logic          not_empty;
  logic [29:0]   head_addr;
  logic [29:0]   next_addr;
  logic          head_hit;
  logic          redirect;
  logic          pop;
  logic          wr_en;
  logic          unused_pc_lsb;

  assign unused_pc_lsb = ^pc_i[1:0];

  always_comb begin
    not_empty = (count_q != '0);
    head_addr = entry_addr_q[head_q];
    head_hit  = not_empty && (head_addr == pc_i[31:2]);
    next_addr = not_empty ? head_addr : fpc_q;
    redirect  = fetch_en_i && (pc_i[31:2] != next_addr);
    pop       = fetch_en_i && head_hit && !redirect;
  end

  assign instr_valid_o = head_hit;
  assign stall_o       = ~head_hit;
  assign instr_o       = head_hit ? entry_data_q[head_q] : 32'h0;
  assign mem_req_o     = (state_q != IDLE);
  assign mem_addr_o    = {req_addr_q, 2'b00};

  always_comb begin
    state_d    = state_q;
    fpc_d      = fpc_q;
    req_addr_d = req_addr_q;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!redirect && (count_q < FULL)) begin
          state_d    = REQ;
          req_addr_d = fpc_q;
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          state_d = IDLE;
          if (!redirect) begin
            wr_en = 1'b1;
            fpc_d = req_addr_q + 30'd1;
          end
        end else if (redirect) begin
          // The memory still owes this response; it is absorbed in DROP.
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ack_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      fpc_d = pc_i[31:2];
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop) begin
        head_d = head_q + PW'(1);
      end
      if (wr_en) begin
        tail_d = tail_q + PW'(1);
      end
      case ({wr_en, pop})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      fpc_q      <= RESET_PC[31:2];
      req_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      fpc_q      <= fpc_d;
      req_addr_q <= req_addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !reset) begin
      entry_addr_q[tail_q] <= req_addr_q;
      entry_data_q[tail_q] <= mem_rdata_i;
    end
  end

endmodule
